// File: rtl/car_pkg.sv
// Shared command codes, door encodings and FSM states
// for the elevator car drive/door plant model.
package car_pkg;

   localparam logic [1:0] ENG_IDLE   = 2'd0;
   localparam logic [1:0] ENG_DOWN   = 2'd1;
   localparam logic [1:0] ENG_UP     = 2'd2;
   localparam logic [1:0] ENG_RSVD   = 2'd3;

   localparam logic [1:0] DOOR_IDLE  = 2'd0;
   localparam logic [1:0] DOOR_OPEN  = 2'd1;
   localparam logic [1:0] DOOR_CLOSE = 2'd2;
   localparam logic [1:0] DOOR_RSVD  = 2'd3;

   localparam logic [1:0] DS_CLOSED  = 2'd0;
   localparam logic [1:0] DS_OPENING = 2'd1;
   localparam logic [1:0] DS_OPEN    = 2'd2;
   localparam logic [1:0] DS_CLOSING = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE_UP,
      S_MOVE_DOWN,
      S_DOOR_OPENING,
      S_DOOR_OPEN,
      S_DOOR_CLOSING
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/car_actuator_seg_timer.sv
// Loadable down-counter shared by car travel and door strokes;
// holds at zero until reloaded.
module seg_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_value,
   output logic         o_zero
);

   logic [W-1:0] r_value;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (r_value != '0) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == '0);

endmodule

// File: rtl/car_actuator.sv
// Elevator car plant: timed half-floor travel, door strokes,
// completion pulse and sticky illegal-command fault.
module car_actuator
   import car_pkg::*;
#(
   parameter int LEVELS        = 8,
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] engine,
   input  logic [1:0] door,
   input  logic       obstruction,
   output logic [3:0] position,
   output logic [2:0] level,
   output logic       at_floor,
   output logic       moving,
   output logic [1:0] door_state,
   output logic       step_done,
   output logic       fault
);

   localparam int TMAX = max_int(TRAVEL_CYCLES, DOOR_CYCLES);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [3:0]    POS_MAX = 4'(2 * (LEVELS - 1));
   localparam logic [TW-1:0] TRAV_LD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);

   state_t     r_state;
   logic [3:0] r_position;
   logic       r_moving;
   logic [1:0] r_door_state;
   logic       r_step_done;
   logic       r_fault;

   logic          w_idle;
   logic          w_free;
   logic          w_eng_up;
   logic          w_eng_dn;
   logic          w_illegal;
   logic          w_start_open;
   logic          w_start_up;
   logic          w_start_dn;
   logic          w_reopen;
   logic          w_close;
   logic          w_load;
   logic [TW-1:0] w_load_val;
   logic [TW-1:0] w_value;
   logic          w_zero;

   assign w_idle   = (r_state == S_IDLE);
   assign w_free   = (w_value == '0);
   assign w_eng_up = (engine == ENG_UP);
   assign w_eng_dn = (engine == ENG_DOWN);

   // Any offending command is flagged; the transitions below ignore it
   assign w_illegal =
      (engine == ENG_RSVD) || (door == DOOR_RSVD) ||
      (engine != ENG_IDLE && r_door_state != DS_CLOSED) ||
      (door != DOOR_IDLE && r_moving) ||
      (!r_moving && w_eng_up && r_position == POS_MAX) ||
      (!r_moving && w_eng_dn && r_position == '0) ||
      (!r_moving && door != DOOR_IDLE && r_position[0]) ||
      (w_idle && door == DOOR_OPEN && engine != ENG_IDLE);

   assign w_start_open = w_idle && w_free &&
                         door == DOOR_OPEN && !r_position[0];
   assign w_start_up   = w_idle && w_free && door != DOOR_OPEN &&
                         w_eng_up && r_position < POS_MAX;
   assign w_start_dn   = w_idle && w_free && door != DOOR_OPEN &&
                         w_eng_dn && r_position != '0;
   assign w_reopen     = (r_state == S_DOOR_CLOSING) &&
                         (obstruction || door == DOOR_OPEN);
   assign w_close      = (r_state == S_DOOR_OPEN) && door == DOOR_CLOSE;

   assign w_load     = w_start_open | w_start_up | w_start_dn |
                       w_reopen | w_close;
   assign w_load_val = (w_start_up | w_start_dn) ? TRAV_LD : DOOR_LD;

   seg_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_value    (w_value),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_position   <= '0;
         r_moving     <= 1'b0;
         r_door_state <= DS_CLOSED;
         r_step_done  <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_step_done <= 1'b0;
         r_fault     <= r_fault | w_illegal;
         unique case (r_state)
            S_IDLE: begin
               if (w_start_open) begin
                  r_state      <= S_DOOR_OPENING;
                  r_door_state <= DS_OPENING;
               end else if (w_start_up) begin
                  r_state  <= S_MOVE_UP;
                  r_moving <= 1'b1;
               end else if (w_start_dn) begin
                  r_state  <= S_MOVE_DOWN;
                  r_moving <= 1'b1;
               end
            end
            S_MOVE_UP: begin
               if (w_zero) begin
                  r_state     <= S_IDLE;
                  r_position  <= r_position + 4'd1;
                  r_moving    <= 1'b0;
                  r_step_done <= 1'b1;
               end
            end
            S_MOVE_DOWN: begin
               if (w_zero) begin
                  r_state     <= S_IDLE;
                  r_position  <= r_position - 4'd1;
                  r_moving    <= 1'b0;
                  r_step_done <= 1'b1;
               end
            end
            S_DOOR_OPENING: begin
               if (w_zero) begin
                  r_state      <= S_DOOR_OPEN;
                  r_door_state <= DS_OPEN;
               end
            end
            S_DOOR_OPEN: begin
               if (w_close) begin
                  r_state      <= S_DOOR_CLOSING;
                  r_door_state <= DS_CLOSING;
               end
            end
            S_DOOR_CLOSING: begin
               if (w_reopen) begin
                  r_state      <= S_DOOR_OPENING;
                  r_door_state <= DS_OPENING;
               end else if (w_zero) begin
                  r_state      <= S_IDLE;
                  r_door_state <= DS_CLOSED;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign position   = r_position;
   assign level      = r_position[3:1];
   assign at_floor   = !r_position[0] && !r_moving;
   assign moving     = r_moving;
   assign door_state = r_door_state;
   assign step_done  = r_step_done;
   assign fault      = r_fault;

endmodule

// File: tb/tb_car_actuator.sv
// Self-checking bench for car_actuator: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_car_actuator;

   localparam int TC   = 16;
   localparam int DC   = 8;
   localparam int LV   = 8;
   localparam int PMAX = 2 * (LV - 1);

   localparam int A_NONE = 0;
   localparam int A_UP   = 1;
   localparam int A_DN   = 2;
   localparam int A_OPNG = 3;
   localparam int A_OPEN = 4;
   localparam int A_CLSG = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] engine;
   logic [1:0] door;
   logic       obstruction;
   logic [3:0] position;
   logic [2:0] level;
   logic       at_floor;
   logic       moving;
   logic [1:0] door_state;
   logic       step_done;
   logic       fault;

   int errors = 0;
   int checks = 0;

   // behavioural model: current activity and cycles left in it
   int m_pos;
   int m_act;
   int m_rem;
   bit m_step;
   bit m_fault;

   typedef struct {
      logic [1:0] e;
      logic [1:0] d;
      logic       o;
      int         n;
      logic [3:0] pos;
      logic [1:0] ds;
      logic       mov;
      logic       stp;
      logic       flt;
   } vec_t;

   vec_t tbl[24];

   always #5 clk = ~clk;

   car_actuator #(
      .LEVELS        (LV),
      .TRAVEL_CYCLES (TC),
      .DOOR_CYCLES   (DC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .engine      (engine),
      .door        (door),
      .obstruction (obstruction),
      .position    (position),
      .level       (level),
      .at_floor    (at_floor),
      .moving      (moving),
      .door_state  (door_state),
      .step_done   (step_done),
      .fault       (fault)
   );

   function automatic logic [12:0] pack(input logic [3:0] p,
                                        input logic m,
                                        input logic [1:0] ds,
                                        input logic s,
                                        input logic f);
      logic [2:0] lv;
      lv = 3'(p / 2);
      return {p, lv, (p % 2 == 0) && !m, m, ds, s, f};
   endfunction

   function automatic logic [12:0] dut_out();
      return {position, level, at_floor, moving, door_state,
              step_done, fault};
   endfunction

   function automatic logic [12:0] model_out();
      logic       mv;
      logic [1:0] ds;
      mv = (m_act == A_UP) || (m_act == A_DN);
      ds = (m_act == A_OPNG) ? 2'd1 :
           (m_act == A_OPEN) ? 2'd2 :
           (m_act == A_CLSG) ? 2'd3 : 2'd0;
      return pack(4'(m_pos), mv, ds, m_step, m_fault);
   endfunction

   task automatic chk(input string nm, input logic [12:0] got,
                      input logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got pos/lvl/flr/mov/ds/stp/flt=%h want=%h",
                  nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pos   = 0;
      m_act   = A_NONE;
      m_rem   = 0;
      m_step  = 0;
      m_fault = 0;
   endtask

   task automatic model_step(input logic [1:0] e, input logic [1:0] d,
                             input logic o);
      bit mv;
      bit closed;
      bit ill;
      mv     = (m_act == A_UP) || (m_act == A_DN);
      closed = (m_act == A_NONE) || mv;
      ill = (e == 3) || (d == 3) ||
            (e != 0 && !closed) ||
            (d != 0 && mv) ||
            (!mv && e == 2 && m_pos == PMAX) ||
            (!mv && e == 1 && m_pos == 0) ||
            (!mv && d != 0 && m_pos % 2 == 1) ||
            (m_act == A_NONE && d == 1 && e != 0);
      m_step = 0;
      case (m_act)
         A_NONE: begin
            if (d == 1) begin
               if (m_pos % 2 == 0) begin
                  m_act = A_OPNG;
                  m_rem = DC;
               end
            end else if (e == 2 && m_pos < PMAX) begin
               m_act = A_UP;
               m_rem = TC;
            end else if (e == 1 && m_pos > 0) begin
               m_act = A_DN;
               m_rem = TC;
            end
         end
         A_UP, A_DN: begin
            m_rem--;
            if (m_rem == 0) begin
               m_pos  = m_pos + ((m_act == A_UP) ? 1 : -1);
               m_step = 1;
               m_act  = A_NONE;
            end
         end
         A_OPNG: begin
            m_rem--;
            if (m_rem == 0) m_act = A_OPEN;
         end
         A_OPEN: begin
            if (d == 2) begin
               m_act = A_CLSG;
               m_rem = DC;
            end
         end
         default: begin
            if (o || d == 1) begin
               m_act = A_OPNG;
               m_rem = DC;
            end else begin
               m_rem--;
               if (m_rem == 0) m_act = A_NONE;
            end
         end
      endcase
      if (ill) m_fault = 1;
   endtask

   // called at a negedge; returns at the following negedge
   task automatic tick(input logic [1:0] e, input logic [1:0] d,
                       input logic o);
      engine      = e;
      door        = d;
      obstruction = o;
      @(posedge clk);
      model_step(e, d, o);
      @(negedge clk);
   endtask

   task automatic do_reset();
      engine      = 2'd0;
      door        = 2'd0;
      obstruction = 1'b0;
      reset       = 1'b0;
      model_reset();
      @(negedge clk);
      chk("reset", dut_out(), pack(4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
      reset = 1'b1;
   endtask

   task automatic rand_inputs(input bit legal, output logic [1:0] e,
                              output logic [1:0] d, output logic o);
      int r;
      r = $urandom_range(0, 99);
      e = 2'd0;
      d = 2'd0;
      o = ($urandom_range(0, 9) == 0);
      if (!legal) begin
         e = (r < 40) ? 2'd0 : (r < 68) ? 2'd2 : (r < 96) ? 2'd1 : 2'd3;
         r = $urandom_range(0, 99);
         d = (r < 80) ? 2'd0 : (r < 88) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
      end else if (m_act == A_UP || m_act == A_DN) begin
         e = 2'($urandom_range(0, 2));
      end else if (m_act != A_NONE) begin
         d = 2'($urandom_range(0, 2));
      end else if (m_pos % 2 == 1) begin
         e = (r < 50) ? 2'd2 : 2'd1;
      end else if (r < 20) begin
         d = 2'd1;
      end else if (r < 55 && m_pos < PMAX) begin
         e = 2'd2;
      end else if (r < 90 && m_pos > 0) begin
         e = 2'd1;
      end
   endtask

   initial begin
      tbl[0]  = '{2'd2, 2'd0, 1'b0, 17, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{2'd2, 2'd0, 1'b0, 17, 4'd2, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{2'd0, 2'd0, 1'b0,  1, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{2'd1, 2'd0, 1'b0,  1, 4'd2, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{2'd0, 2'd0, 1'b0, 15, 4'd2, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{2'd0, 2'd0, 1'b0,  1, 4'd1, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{2'd0, 2'd0, 1'b0,  5, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{2'd1, 2'd0, 1'b0,  1, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{2'd0, 2'd0, 1'b0, 16, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{2'd0, 2'd1, 1'b0,  1, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{2'd0, 2'd0, 1'b0,  6, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{2'd0, 2'd0, 1'b0,  1, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{2'd0, 2'd0, 1'b0,  1, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{2'd0, 2'd2, 1'b0,  1, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{2'd0, 2'd0, 1'b0,  7, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{2'd0, 2'd0, 1'b0,  1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{2'd0, 2'd1, 1'b0,  9, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{2'd0, 2'd2, 1'b0,  1, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{2'd0, 2'd0, 1'b0,  3, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{2'd0, 2'd0, 1'b1,  1, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{2'd0, 2'd0, 1'b0,  7, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
      tbl[21] = '{2'd0, 2'd0, 1'b0,  1, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
      tbl[22] = '{2'd2, 2'd0, 1'b0,  1, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{2'd0, 2'd0, 1'b0,  3, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < tbl[i].n; k++)
            tick(tbl[i].e, tbl[i].d, tbl[i].o);
         chk($sformatf("vec%0d", i), dut_out(),
             pack(tbl[i].pos, tbl[i].mov, tbl[i].ds,
                  tbl[i].stp, tbl[i].flt));
      end

      do_reset();

      // climb to the top floor with engine=up held throughout
      begin
         int n;
         n = 0;
         while (n < 400 && !(position == 4'(PMAX) && step_done)) begin
            tick(2'd2, 2'd0, 1'b0);
            n++;
         end
         checks++;
         if (n != PMAX * (TC + 1)) begin
            errors++;
            $display("FAIL climb_cycles: got %0d want %0d",
                     n, PMAX * (TC + 1));
         end
         chk("climb_top", dut_out(),
             pack(4'(PMAX), 1'b0, 2'd0, 1'b1, 1'b0));
         for (int k = 0; k < 3; k++) tick(2'd2, 2'd0, 1'b0);
         chk("top_limit", dut_out(),
             pack(4'(PMAX), 1'b0, 2'd0, 1'b0, 1'b1));
      end

      do_reset();

      // asynchronous reset in the middle of a segment
      for (int k = 0; k < 20; k++) tick(2'd2, 2'd0, 1'b0);
      chk("pre_async", dut_out(), pack(4'd1, 1'b1, 2'd0, 1'b0, 1'b0));
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst", dut_out(), pack(4'd0, 1'b0, 2'd0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         for (int k = 0; k < 400; k++) begin
            logic [1:0] e;
            logic [1:0] d;
            logic       o;
            rand_inputs(ep % 3 != 2, e, d, o);
            tick(e, d, o);
            chk($sformatf("rand%0d_%0d", ep, k), dut_out(), model_out());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
